// File: rtl/im_fetch_responder.sv
// Fetch-side instruction memory: sequential program load after reset, then one-cycle registered fetch.
// Load port is ready only while loading; en=0 stalls the fetch outputs exactly like the PC register.
module im_fetch_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [31:0]       F_PC,
  input  logic              en,
  output logic [31:0]       D_instr,
  output logic [4:0]        D_excCode,
  output logic              D_instrValid,
  output logic [ADDR_W:0]   loaded_count
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] ptr_q;
  logic              load_fire;
  logic              last_slot;
  logic [31:0]       pc_off;
  logic              addr_fault;
  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       rd_word;
  logic [4:0]        rd_exc;

  assign last_slot = (ptr_q == ADDR_W'(DEPTH_WORDS - 1));

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    load_fire  = 1'b0;
    case (state_q)
      S_LOAD: begin
        load_ready = 1'b1;
        load_fire  = load_valid;
        if (load_valid && (load_last || last_slot)) state_d = S_RUN;
      end
      default: ;
    endcase
  end

  // All three fault causes collapse onto the single AdEL code.
  assign pc_off     = F_PC - BASE_ADDR;
  assign addr_fault = (F_PC[1:0] != 2'b00) || (F_PC < BASE_ADDR) ||
                      ((pc_off >> 2) >= 32'(DEPTH_WORDS));
  assign rd_idx     = pc_off[ADDR_W+1:2];

  // Words beyond loaded_count are stale from an earlier program and read as nop.
  always_comb begin
    rd_word = 32'h0;
    rd_exc  = EXC_NONE;
    if (addr_fault) rd_exc = EXC_ADEL;
    else if ({1'b0, rd_idx} < loaded_count) rd_word = mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (load_fire) mem[ptr_q] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD;
      ptr_q        <= '0;
      loaded_count <= '0;
      D_instr      <= 32'h0;
      D_excCode    <= EXC_NONE;
      D_instrValid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_fire) begin
        ptr_q        <= last_slot ? ptr_q : ptr_q + 1'b1;
        loaded_count <= loaded_count + 1'b1;
      end
      if (state_q == S_LOAD) begin
        D_instr      <= 32'h0;
        D_excCode    <= EXC_NONE;
        D_instrValid <= 1'b0;
      end else if (en) begin
        D_instr      <= rd_word;
        D_excCode    <= rd_exc;
        D_instrValid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_im_fetch_responder.sv
// Bench for im_fetch_responder: directed load/fetch vectors, fetch results checked via an expected-value queue.
module tb_im_fetch_responder;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [31:0] F_PC;
  logic        en;
  logic [31:0] D_instr;
  logic [4:0]  D_excCode;
  logic        D_instrValid;
  logic [12:0] loaded_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  exc;
  } exp_t;
  exp_t exp_q[$];

  im_fetch_responder dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready),
    .F_PC(F_PC), .en(en),
    .D_instr(D_instr), .D_excCode(D_excCode), .D_instrValid(D_instrValid),
    .loaded_count(loaded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: a fetch issued (en=1) at an edge is compared at the following negedge.
  always begin
    logic fired;
    exp_t e;
    @(posedge clk);
    fired = en && !reset;
    @(negedge clk);
    if (fired) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fetch", 32'(D_instrValid), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("fetch_instr", D_instr, e.instr);
        check("fetch_exc", 32'(D_excCode), 32'(e.exc));
        check("fetch_valid", 32'(D_instrValid), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ei, input logic [4:0] ee);
    exp_t e;
    e.instr = ei;
    e.exc   = ee;
    exp_q.push_back(e);
    F_PC = pc;
    en   = 1'b1;
    tick();
    en   = 1'b0;
  endtask

  task automatic check_outputs(input string name, input logic [31:0] ei, input logic [4:0] ee,
                               input logic ev);
    check({name, "_instr"}, D_instr, ei);
    check({name, "_exc"}, 32'(D_excCode), 32'(ee));
    check({name, "_valid"}, 32'(D_instrValid), 32'(ev));
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = 32'h0; load_last = 1'b0;
    F_PC = 32'h0; en = 1'b0;
    tick();
    tick();
    check_outputs("reset", 32'h0, 5'd0, 1'b0);
    check("reset_load_ready", 32'(load_ready), 32'd1);
    check("reset_count", 32'(loaded_count), 32'd0);
    reset = 1'b0;

    // Three-word program
    load_word(32'h3C01_1234, 1'b0);
    load_word(32'h3421_0005, 1'b0);
    check("ready_mid_load", 32'(load_ready), 32'd1);
    load_word(32'h0000_0000, 1'b1);
    check("ready_after_last", 32'(load_ready), 32'd0);
    check("count_3", 32'(loaded_count), 32'd3);

    fetch(32'h3000, 32'h3C01_1234, 5'd0);
    fetch(32'h3004, 32'h3421_0005, 5'd0);
    fetch(32'h3008, 32'h0000_0000, 5'd0);
    fetch(32'h300C, 32'h0000_0000, 5'd0);

    // Stall holds a non-zero result while F_PC moves
    fetch(32'h3004, 32'h3421_0005, 5'd0);
    F_PC = 32'h3008;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outputs("stall", 32'h3421_0005, 5'd0, 1'b1);
    end
    fetch(32'h3008, 32'h0000_0000, 5'd0);

    // Address faults and the last in-range word
    fetch(32'h3002, 32'h0, 5'd4);
    fetch(32'h2FFC, 32'h0, 5'd4);
    fetch(32'h7000, 32'h0, 5'd4);
    tick();
    check_outputs("stall_fault", 32'h0, 5'd4, 1'b1);
    fetch(32'h6FFC, 32'h0, 5'd0);
    fetch(32'h3000, 32'h3C01_1234, 5'd0);

    // Full-depth load without load_last
    do_reset();
    check_outputs("reset2", 32'h0, 5'd0, 1'b0);
    load_valid = 1'b1;
    load_last  = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      load_data = 32'hA500_0000 | 32'(i);
      tick();
    end
    check("full_ready", 32'(load_ready), 32'd0);
    check("full_count", 32'(loaded_count), 32'd4096);
    load_data = 32'hDEAD_BEEF;
    tick();
    tick();
    load_valid = 1'b0;
    check("full_count_hold", 32'(loaded_count), 32'd4096);
    fetch(32'h6FFC, 32'hA500_0FFF, 5'd0);
    fetch(32'h3000, 32'hA500_0000, 5'd0);
    fetch(32'h3004, 32'hA500_0001, 5'd0);
    fetch(32'h7000, 32'h0, 5'd4);

    // Reset in the middle of a load
    do_reset();
    load_word(32'h1111_1111, 1'b0);
    load_word(32'h2222_2222, 1'b0);
    check("midload_count", 32'(loaded_count), 32'd2);
    do_reset();
    check("midreset_count", 32'(loaded_count), 32'd0);
    check("midreset_ready", 32'(load_ready), 32'd1);
    check("midreset_valid", 32'(D_instrValid), 32'd0);
    load_word(32'hAAAA_5555, 1'b1);
    check("reload_count", 32'(loaded_count), 32'd1);
    check("reload_ready", 32'(load_ready), 32'd0);
    fetch(32'h3004, 32'h0, 5'd0);
    fetch(32'h3000, 32'hAAAA_5555, 5'd0);

    repeat (4) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d fetch results never observed, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
